// File: rtl/dphy_lp_pkg.sv
// Shared D-PHY low-power definitions: RX line-state encoding and LP line codes {Dp, Dn}.
package dphy_lp_pkg;

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    STOP      = 3'd1,
    HS_RQST   = 3'd2,
    HS_PREP   = 3'd3,
    HS_RX     = 3'd4,
    ESC_WAIT  = 3'd5,
    WAIT_STOP = 3'd6
  } lp_state_t;

  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP00 = 2'b00;

endpackage

// File: rtl/lp_sync2.sv
// Two-flop synchronizer of configurable width with a configurable reset value.
module lp_sync2 #(
  parameter int               W       = 1,
  parameter logic [W-1:0]     RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_lp_fsm.sv
// D-PHY RX low-power line-state FSM: detects SoT (LP-11 -> LP-01 -> LP-00), sequences
// HS termination/settle, reports end of HS, illegal sequences and escape entry.
module rx_lp_fsm
  import dphy_lp_pkg::*;
#(
  parameter int T_INIT      = 4,
  parameter int T_LPX_MIN   = 2,
  parameter int T_TERM_EN   = 1,
  parameter int T_HS_SETTLE = 4,
  parameter int CNT_W       = 8
) (
  input  logic RX_BYTE_clk,
  input  logic RX_rst,
  input  logic LP_Dp,
  input  logic LP_Dn,
  output logic RX_STOP_STATE,
  output logic RX_HS_TERM_EN,
  output logic RX_HS_ACTIVE,
  output logic RX_HS_END,
  output logic RX_ERR_SOT_SEQ,
  output logic RX_ESC_DET
);

  localparam logic [CNT_W-1:0] INIT_TH   = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0] LPX_TH    = CNT_W'(T_LPX_MIN);
  localparam logic [CNT_W-1:0] TERM_TH   = CNT_W'(T_TERM_EN);
  localparam logic [CNT_W-1:0] SETTLE_TH = CNT_W'(T_HS_SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]       lp_s;
  lp_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             hs_end_q;
  logic             err_q;
  logic             esc_q;

  lp_sync2 #(
    .W       (2),
    .RST_VAL (LP11)
  ) u_sync (
    .clk   (RX_BYTE_clk),
    .rst_n (RX_rst),
    .d     ({LP_Dp, LP_Dn}),
    .q     (lp_s)
  );

  // Every transition also clears cnt; otherwise cnt counts up and holds at its maximum.
  always_ff @(posedge RX_BYTE_clk or negedge RX_rst) begin
    if (!RX_rst) begin
      state    <= INIT;
      cnt      <= '0;
      hs_end_q <= 1'b0;
      err_q    <= 1'b0;
      esc_q    <= 1'b0;
    end else begin
      hs_end_q <= 1'b0;
      err_q    <= 1'b0;
      esc_q    <= 1'b0;
      cnt      <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      case (state)
        INIT: begin
          if (lp_s != LP11) begin
            cnt <= '0;
          end else if (cnt >= INIT_TH) begin
            state <= STOP;
            cnt   <= '0;
          end
        end
        STOP: begin
          case (lp_s)
            LP01: begin
              state <= HS_RQST;
              cnt   <= '0;
            end
            LP10: begin
              state <= ESC_WAIT;
              cnt   <= '0;
              esc_q <= 1'b1;
            end
            LP00: begin
              state <= WAIT_STOP;
              cnt   <= '0;
              err_q <= 1'b1;
            end
            default: ;
          endcase
        end
        HS_RQST: begin
          case (lp_s)
            LP00: begin
              cnt <= '0;
              if (cnt >= LPX_TH) begin
                state <= HS_PREP;
              end else begin
                state <= WAIT_STOP;
                err_q <= 1'b1;
              end
            end
            LP11: begin
              state <= STOP;
              cnt   <= '0;
              err_q <= 1'b1;
            end
            LP10: begin
              state <= WAIT_STOP;
              cnt   <= '0;
              err_q <= 1'b1;
            end
            default: ;
          endcase
        end
        HS_PREP: begin
          // A return to LP-11 wins over the settle exit; 01/10 are unreliable here.
          if (lp_s == LP11) begin
            state <= STOP;
            cnt   <= '0;
            err_q <= 1'b1;
          end else if (cnt == SETTLE_TH) begin
            state <= HS_RX;
            cnt   <= '0;
          end
        end
        HS_RX: begin
          if (lp_s == LP11) begin
            state    <= STOP;
            cnt      <= '0;
            hs_end_q <= 1'b1;
          end
        end
        ESC_WAIT, WAIT_STOP: begin
          if (lp_s == LP11) begin
            state <= STOP;
            cnt   <= '0;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign RX_STOP_STATE  = (state == STOP);
  assign RX_HS_TERM_EN  = ((state == HS_PREP) && (cnt >= TERM_TH)) || (state == HS_RX);
  assign RX_HS_ACTIVE   = (state == HS_RX);
  assign RX_HS_END      = hs_end_q;
  assign RX_ERR_SOT_SEQ = err_q;
  assign RX_ESC_DET     = esc_q;

endmodule
